// File: rtl/interrupt_ctrl_pkg.sv
// Shared types and defaults for the interrupt claim controller family.
package interrupt_ctrl_pkg;

  localparam int N_INTERRUPTS_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ASSERT    = 2'd1,
    SERVICING = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/interrupt_priority_encoder.sv
// Fixed-priority encoder: the lowest set index of the eligible vector wins.
module interrupt_priority_encoder #(
  parameter int  N_interrupts = 32,
  localparam int ID_W         = $clog2(N_interrupts)
) (
  input  logic [N_interrupts-1:0] eligible,
  output logic [ID_W-1:0]         winner,
  output logic                    any_elig
);

  // Scan from the top down so the last hit, i.e. the lowest index, sticks.
  always_comb begin
    winner = '0;
    for (int i = N_interrupts - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  assign any_elig = |eligible;

endmodule

// File: rtl/interrupt_claim_controller.sv
// Pending-register interrupt controller with a claim/complete handshake.
// Edge pulses latch into pending regardless of the enable mask; the mask only
// decides which pending sources are visible to priority resolution.
module interrupt_claim_controller
  import interrupt_ctrl_pkg::*;
#(
  parameter int  N_interrupts = N_INTERRUPTS_DEFAULT,
  localparam int ID_W         = $clog2(N_interrupts)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_interrupts-1:0] interrupt_requests,
  input  logic [N_interrupts-1:0] interrupt_enable,
  output logic                    irq_out,
  input  logic                    claim_req,
  output logic                    claim_ack,
  output logic                    claim_valid,
  output logic [ID_W-1:0]         claim_id,
  input  logic                    complete_req,
  input  logic [ID_W-1:0]         complete_id,
  output logic                    complete_err,
  output logic [N_interrupts-1:0] pending,
  output logic [ID_W-1:0]         active_id
);

  ctrl_state_t             state;
  ctrl_state_t             next_state;
  logic [N_interrupts-1:0] eligible;
  logic [N_interrupts-1:0] clr;
  logic [ID_W-1:0]         winner;
  logic                    any_elig;
  logic                    claim_legal;
  logic                    complete_legal;

  assign eligible = pending & interrupt_enable;

  interrupt_priority_encoder #(
    .N_interrupts(N_interrupts)
  ) u_prio (
    .eligible (eligible),
    .winner   (winner),
    .any_elig (any_elig)
  );

  // A claim is only honoured while asserting and something is still eligible
  // at the claim edge; a complete only matches the source in service.
  assign claim_legal    = claim_req && (state == ASSERT) && any_elig;
  assign complete_legal = complete_req && (state == SERVICING) && (complete_id == active_id);

  // One-hot clear of the claimed source's pending bit.
  always_comb begin
    clr = '0;
    if (claim_legal) clr[winner] = 1'b1;
  end

  // Next-state decode; irq_out is registered from this so it falls on the claim edge.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (any_elig) next_state = ASSERT;
      end
      ASSERT: begin
        if (claim_req) next_state = any_elig ? SERVICING : IDLE;
        else if (!any_elig) next_state = IDLE;
      end
      SERVICING: begin
        if (complete_legal) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, pending register and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pending      <= '0;
      irq_out      <= 1'b0;
      claim_ack    <= 1'b0;
      claim_valid  <= 1'b0;
      claim_id     <= '0;
      complete_err <= 1'b0;
      active_id    <= '0;
    end else begin
      state        <= next_state;
      // Set after clear so a fresh edge on the claimed bit is never lost.
      pending      <= (pending & ~clr) | interrupt_requests;
      irq_out      <= (next_state == ASSERT);
      claim_ack    <= claim_req;
      claim_valid  <= claim_legal;
      complete_err <= complete_req && !complete_legal;
      if (claim_req) claim_id <= claim_legal ? winner : '0;
      if (claim_legal) active_id <= winner;
    end
  end

endmodule

// File: tb/tb_interrupt_claim_controller.sv
// Directed bench: handshake responses go through a scoreboard checked by a
// monitor; level outputs (irq_out, pending, active_id) are checked inline.
module tb_interrupt_claim_controller;

  localparam int N  = 32;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  interrupt_requests;
  logic [N-1:0]  interrupt_enable;
  logic          irq_out;
  logic          claim_req;
  logic          claim_ack;
  logic          claim_valid;
  logic [IW-1:0] claim_id;
  logic          complete_req;
  logic [IW-1:0] complete_id;
  logic          complete_err;
  logic [N-1:0]  pending;
  logic [IW-1:0] active_id;

  interrupt_claim_controller #(.N_interrupts(N)) dut (
    .clk                (clk),
    .rst                (rst),
    .interrupt_requests (interrupt_requests),
    .interrupt_enable   (interrupt_enable),
    .irq_out            (irq_out),
    .claim_req          (claim_req),
    .claim_ack          (claim_ack),
    .claim_valid        (claim_valid),
    .claim_id           (claim_id),
    .complete_req       (complete_req),
    .complete_id        (complete_id),
    .complete_err       (complete_err),
    .pending            (pending),
    .active_id          (active_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic          valid;
    logic [IW-1:0] id;
  } claim_exp_t;

  claim_exp_t claim_q[$];
  int         err_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop expected handshake responses when the DUT presents them.
  always @(negedge clk) begin
    claim_exp_t e;
    int d;
    if (claim_ack) begin
      checks++;
      if (claim_q.size() == 0) begin
        failures++;
        $display("FAIL claim_ack_unexpected: got ack valid=%0d id=%0d expected none (cycle %0d)",
                 claim_valid, claim_id, cyc);
      end else begin
        e = claim_q.pop_front();
        if (claim_valid !== e.valid || claim_id !== e.id || cyc != e.due) begin
          failures++;
          $display("FAIL claim_resp: got valid=%0d id=%0d cycle=%0d expected valid=%0d id=%0d cycle=%0d",
                   claim_valid, claim_id, cyc, e.valid, e.id, e.due);
        end
      end
    end else if (claim_q.size() > 0 && claim_q[0].due <= cyc) begin
      e = claim_q.pop_front();
      checks++;
      failures++;
      $display("FAIL claim_ack_missing: got no ack expected ack valid=%0d id=%0d at cycle %0d",
               e.valid, e.id, e.due);
    end
    if (complete_err) begin
      checks++;
      if (err_q.size() == 0) begin
        failures++;
        $display("FAIL complete_err_unexpected: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        d = err_q.pop_front();
        if (cyc != d) begin
          failures++;
          $display("FAIL complete_err_timing: got cycle %0d expected cycle %0d", cyc, d);
        end
      end
    end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
      d = err_q.pop_front();
      checks++;
      failures++;
      $display("FAIL complete_err_missing: got 0 expected 1 at cycle %0d", d);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(logic [N-1:0] m);
    interrupt_requests = m;
    tick(1);
    interrupt_requests = '0;
  endtask

  task automatic claim(logic v, logic [IW-1:0] id);
    claim_exp_t e;
    e.due = cyc + 1; e.valid = v; e.id = id;
    claim_q.push_back(e);
    claim_req = 1'b1;
    tick(1);
    claim_req = 1'b0;
  endtask

  task automatic complete(logic [IW-1:0] id, logic exp_err);
    if (exp_err) err_q.push_back(cyc + 1);
    complete_req = 1'b1;
    complete_id  = id;
    tick(1);
    complete_req = 1'b0;
    complete_id  = '0;
  endtask

  initial begin
    claim_exp_t e;
    rst = 1'b1;
    interrupt_requests = '0;
    interrupt_enable   = '1;
    claim_req          = 1'b0;
    complete_req       = 1'b0;
    complete_id        = '0;
    tick(2);
    chk("reset_irq_out", irq_out, 0);
    chk("reset_pending", pending, 0);
    chk("reset_claim_id", claim_id, 0);
    chk("reset_active_id", active_id, 0);
    rst = 1'b0;

    // Basic flow on source 5.
    pulse(32'h0000_0020);
    chk("basic_pending", pending, 32'h0000_0020);
    chk("basic_irq_edge1", irq_out, 0);
    tick(1);
    chk("basic_irq_edge2", irq_out, 1);
    claim(1'b1, 5'd5);
    chk("basic_irq_after_claim", irq_out, 0);
    chk("basic_pending_cleared", pending, 0);
    chk("basic_active_id", active_id, 5);
    complete(5'd5, 1'b0);
    tick(1);
    chk("basic_irq_after_complete", irq_out, 0);

    // Priority: 3 beats 9; re-pend 3 while 9 is in service.
    pulse(32'h0000_0208);
    tick(1);
    chk("prio_irq", irq_out, 1);
    claim(1'b1, 5'd3);
    chk("prio_pending_9_left", pending, 32'h0000_0200);
    complete(5'd3, 1'b0);
    chk("prio_irq_complete_edge", irq_out, 0);
    tick(1);
    chk("prio_irq_reassert", irq_out, 1);
    claim(1'b1, 5'd9);
    pulse(32'h0000_0008);
    chk("prio_repend_3", pending, 32'h0000_0008);
    chk("prio_irq_in_service", irq_out, 0);
    complete(5'd9, 1'b0);
    tick(1);
    chk("prio_irq_for_repend", irq_out, 1);
    claim(1'b1, 5'd3);
    complete(5'd3, 1'b0);

    // Masking: pending latches while disabled; enable makes it visible.
    interrupt_enable = ~32'h0000_0080;
    pulse(32'h0000_0080);
    chk("mask_pending", pending, 32'h0000_0080);
    tick(2);
    chk("mask_irq_low", irq_out, 0);
    interrupt_enable = '1;
    tick(1);
    chk("mask_irq_on_enable", irq_out, 1);
    interrupt_enable = ~32'h0000_0080;
    tick(1);
    chk("mask_irq_drop", irq_out, 0);
    chk("mask_pending_kept", pending, 32'h0000_0080);
    interrupt_enable = '1;
    tick(1);
    chk("mask_irq_again", irq_out, 1);
    claim(1'b1, 5'd7);
    complete(5'd7, 1'b0);

    // Claim while eligibility vanishes at the claim edge.
    pulse(32'h0000_0040);
    tick(1);
    interrupt_enable = '0;
    claim(1'b0, 5'd0);
    chk("noelig_irq", irq_out, 0);
    chk("noelig_pending_kept", pending, 32'h0000_0040);
    interrupt_enable = '1;
    tick(1);
    claim(1'b1, 5'd6);
    complete(5'd6, 1'b0);

    // Illegal handshakes.
    claim(1'b0, 5'd0);
    complete(5'd0, 1'b1);
    pulse(32'h0000_0004);
    tick(1);
    claim(1'b1, 5'd2);
    complete(5'd4, 1'b1);
    chk("illegal_active_id_kept", active_id, 2);
    claim(1'b0, 5'd0);
    chk("illegal_claim_id_zeroed", claim_id, 0);
    complete(5'd2, 1'b0);

    // Simultaneous claim and complete while asserting.
    pulse(32'h0000_0002);
    tick(1);
    e.due = cyc + 1; e.valid = 1'b1; e.id = 5'd1;
    claim_q.push_back(e);
    err_q.push_back(cyc + 1);
    claim_req = 1'b1; complete_req = 1'b1; complete_id = 5'd1;
    tick(1);
    claim_req = 1'b0; complete_req = 1'b0; complete_id = '0;
    chk("simul_active_id", active_id, 1);
    complete(5'd1, 1'b0);

    // Same-cycle set and claim-clear on bit 0.
    pulse(32'h0000_0001);
    tick(1);
    e.due = cyc + 1; e.valid = 1'b1; e.id = 5'd0;
    claim_q.push_back(e);
    claim_req = 1'b1; interrupt_requests = 32'h0000_0001;
    tick(1);
    claim_req = 1'b0; interrupt_requests = '0;
    chk("setclr_pending_kept", pending, 32'h0000_0001);
    complete(5'd0, 1'b0);
    tick(1);
    chk("setclr_irq_reassert", irq_out, 1);
    claim(1'b1, 5'd0);
    complete(5'd0, 1'b0);

    // Asynchronous reset in SERVICING with pending 0x11.
    pulse(32'h0000_0004);
    tick(1);
    claim(1'b1, 5'd2);
    pulse(32'h0000_0011);
    chk("rst_pre_pending", pending, 32'h0000_0011);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_pending", pending, 0);
    chk("rst_async_active_id", active_id, 0);
    chk("rst_async_claim_id", claim_id, 0);
    chk("rst_async_irq", irq_out, 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    chk("rst_post_irq", irq_out, 0);
    chk("rst_post_pending", pending, 0);
    complete(5'd2, 1'b1);

    tick(3);
    while (claim_q.size() > 0) begin
      e = claim_q.pop_front();
      checks++; failures++;
      $display("FAIL claim_leftover: got nothing expected valid=%0d id=%0d", e.valid, e.id);
    end
    while (err_q.size() > 0) begin
      void'(err_q.pop_front());
      checks++; failures++;
      $display("FAIL err_leftover: got nothing expected complete_err");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
